// File: rtl/tff_toggle_ctrl.sv
// tff_toggle_ctrl
//
// Upstream control stage for the T flip-flop block. It takes a raw, bouncing,
// asynchronous push-button and turns it into clean single-cycle toggle
// commands (en/t) for the flip-flop. It also provides an optional auto-repeat
// while the button is held.
//
// Processing chain:
//   btn_in -> SYNC_STAGES-flop synchroniser -> debounce counter -> btn_level
//   btn_level rising edge -> press FSM -> en/t pulse (+ press_count)
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   btn_in      in   raw button, active-high, asynchronous, may bounce
//   repeat_en   in   1 = auto-repeat while the button is held (quasi-static)
//   en          out  enable to the flip-flop, always equal to t
//   t           out  one-cycle toggle pulse per toggle event
//   btn_level   out  debounced, synchronised button level
//   press_count out  8-bit count of issued toggle pulses, wraps at 8'hFF
module tff_toggle_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       en,
  output logic       t,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER   = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] RPT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2,
    HELD_WAIT   = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Debounce: the level follows synced only after synced has disagreed
  // with it for DEBOUNCE_CYCLES consecutive cycles. Any agreement in
  // between clears the count, so short glitches are swallowed.
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (synced != level_q) begin
      // The edge on which the count would reach DEBOUNCE_CYCLES commits
      // the new level instead of storing the count.
      if (db_cnt_q == DB_LAST) begin
        level_d  = synced;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + RPT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // ------------------------------------------------------------------
  // Press / auto-repeat FSM with registered pulse and press counter.
  // The repeat counter expires when it is 1 on an edge, so a load of N
  // yields the next pulse exactly N edges after the previous one.
  // Release is checked before expiry in every HELD_* state, so a release
  // coinciding with expiry produces no pulse.
  // ------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic             level_prev_q;
  logic             pulse_q;
  logic [7:0]       press_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rpt_cnt_q     <= '0;
      level_prev_q  <= 1'b0;
      pulse_q       <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      pulse_q      <= 1'b0;
      level_prev_q <= level_q;
      case (state_q)
        IDLE: begin
          if (level_q && !level_prev_q) begin
            pulse_q       <= 1'b1;
            press_count_q <= press_count_q + 8'd1;
            rpt_cnt_q     <= RPT_DELAY;
            state_q       <= HELD_DELAY;
          end
        end
        HELD_DELAY: begin
          if (!level_q) begin
            state_q <= IDLE;
          end else if (rpt_cnt_q == RPT_ONE) begin
            if (repeat_en) begin
              pulse_q       <= 1'b1;
              press_count_q <= press_count_q + 8'd1;
              rpt_cnt_q     <= RPT_PER;
              state_q       <= HELD_REPEAT;
            end else begin
              state_q <= HELD_WAIT;
            end
          end else begin
            rpt_cnt_q <= rpt_cnt_q - RPT_ONE;
          end
        end
        HELD_REPEAT: begin
          if (!level_q) begin
            state_q <= IDLE;
          end else if (rpt_cnt_q == RPT_ONE) begin
            if (repeat_en) begin
              pulse_q       <= 1'b1;
              press_count_q <= press_count_q + 8'd1;
              rpt_cnt_q     <= RPT_PER;
            end else begin
              state_q <= HELD_WAIT;
            end
          end else begin
            rpt_cnt_q <= rpt_cnt_q - RPT_ONE;
          end
        end
        HELD_WAIT: begin
          if (!level_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign en          = pulse_q;
  assign t           = pulse_q;
  assign btn_level   = level_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_tff_toggle_ctrl.sv
// Directed testbench for tff_toggle_ctrl. Expected pulse cycles are pushed to
// a queue when the stimulus is driven; a monitor pops and checks them as the
// DUT emits t/en pulses, and flags spurious or missing pulses.
module tb_tff_toggle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       repeat_en;
  logic       en;
  logic       t;
  logic       btn_level;
  logic [7:0] press_count;

  int         cyc;
  int         total;
  int         bad;
  int         exp_q[$];
  logic [7:0] model_cnt;

  tff_toggle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .en         (en),
    .t          (t),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor / scoreboard consumer, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("en_eq_t", 32'(en), 32'(t));
      if (t) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", 32'(t), 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          model_cnt = model_cnt + 8'd1;
          check("pulse_cycle", 32'(cyc), 32'(e));
          check("press_count", 32'(press_count), 32'(model_cnt));
          $display("pulse at cycle %0d (expected %0d) press_count=%0d", cyc, e, press_count);
        end
      end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("pulse_due", 32'(cyc), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int p0;
    logic [7:0] start_cnt;
    total     = 0;
    bad       = 0;
    model_cnt = 8'd0;

    // Reset with the button held.
    rst_n     = 1'b0;
    btn_in    = 1'b1;
    repeat_en = 1'b0;
    tick(3);
    check("rst_en", 32'(en), 32'd0);
    check("rst_t", 32'(t), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_count", 32'(press_count), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(cyc + 7);
    tick(5);
    check("rstrel_level_e5", 32'(btn_level), 32'd0);
    tick(1);
    check("rstrel_level_e6", 32'(btn_level), 32'd1);
    tick(5);
    check("rstrel_count", 32'(press_count), 32'd1);
    btn_in = 1'b0;
    tick(15);

    // Clean press without auto-repeat, held 40 cycles.
    btn_in = 1'b1;
    exp_q.push_back(cyc + 7);
    tick(47);
    check("clean_level_held", 32'(btn_level), 32'd1);
    btn_in = 1'b0;
    tick(12);
    check("clean_level_rel", 32'(btn_level), 32'd0);
    check("clean_q_empty", 32'(exp_q.size()), 32'd0);
    check("clean_count", 32'(press_count), 32'(model_cnt));

    // Bounce rejection, then a stable press.
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(2);
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(12);
    check("bounce_level", 32'(btn_level), 32'd0);
    btn_in = 1'b1;
    exp_q.push_back(cyc + 7);
    tick(10);
    btn_in = 1'b0;
    tick(12);
    check("bounce_q_empty", 32'(exp_q.size()), 32'd0);

    // Auto-repeat: btn_level stays high for 50 cycles after the first pulse.
    repeat_en = 1'b1;
    btn_in    = 1'b1;
    p0 = cyc + 7;
    exp_q.push_back(p0);
    exp_q.push_back(p0 + 16);
    exp_q.push_back(p0 + 24);
    exp_q.push_back(p0 + 32);
    exp_q.push_back(p0 + 40);
    exp_q.push_back(p0 + 48);
    start_cnt = model_cnt;
    tick(7 + 44);
    btn_in = 1'b0;
    tick(20);
    check("repeat_q_empty", 32'(exp_q.size()), 32'd0);
    check("repeat_count", 32'(press_count), 32'(start_cnt + 8'd6));

    // Release lands on the same edge as the REPEAT_DELAY expiry.
    btn_in = 1'b1;
    exp_q.push_back(cyc + 7);
    start_cnt = model_cnt + 8'd1;
    tick(16);
    btn_in = 1'b0;
    tick(12);
    check("collide_q_empty", 32'(exp_q.size()), 32'd0);
    check("collide_count", 32'(press_count), 32'(start_cnt));
    // FSM must be back in IDLE: a new press is accepted.
    repeat_en = 1'b0;
    btn_in    = 1'b1;
    exp_q.push_back(cyc + 7);
    tick(10);
    btn_in = 1'b0;
    tick(12);
    check("repress_q_empty", 32'(exp_q.size()), 32'd0);

    // 256 pulses via auto-repeat: counter wraps back to its start value.
    repeat_en = 1'b1;
    btn_in    = 1'b1;
    start_cnt = model_cnt;
    p0 = cyc + 7;
    exp_q.push_back(p0);
    for (int k = 0; k < 255; k++) exp_q.push_back(p0 + 16 + 8 * k);
    tick(7 + 2048 + 1);
    check("wrap_q_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_count", 32'(press_count), 32'(start_cnt));

    // Reset asserted in HELD_REPEAT just before the next repeat edge.
    tick(6);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_cnt = 8'd0;
    check("midrst_en", 32'(en), 32'd0);
    check("midrst_t", 32'(t), 32'd0);
    check("midrst_level", 32'(btn_level), 32'd0);
    check("midrst_count", 32'(press_count), 32'd0);
    btn_in = 1'b0;
    tick(3);
    check("midrst_t_hold", 32'(t), 32'd0);
    check("midrst_count_hold", 32'(press_count), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_count", 32'(press_count), 32'd0);
    check("post_rst_level", 32'(btn_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
